wb_target_mem: RTL and testbench
================================

Name: wb_target_mem

Overview:
- Wishbone classic (B4, non-pipelined) target for the smoke-test environment.
- Sits directly downstream of the Wishbone initiator BFM, replacing the one-cycle loopback ack.
- Provides a word-addressed, byte-selectable SRAM with programmable wait states and error response.
- Gives Python-driven tests real read-after-write data, latency and error behaviour to check.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, minimum 4.
- WAIT_STATES, 0, extra cycles inserted before ack/err; range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*4.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- adr  in  32  byte address from initiator.
- dat_w  in  32  write data from initiator.
- dat_r  out  32  read data to initiator.
- stb  in  1  strobe.
- cyc  in  1  bus cycle.
- we  in  1  1 = write, 0 = read.
- sel  in  4  byte lane enables; bit i maps to dat[8i+7:8i].
- ack  out  1  normal termination.
- err  out  1  error termination.

Behaviour:
- Reset: ack=0, err=0, dat_r=0, FSM=IDLE, wait counter=0. RAM contents are not cleared and are retained across reset.
- Decode:
  - in_range when BASE_ADDR <= adr < BASE_ADDR+DEPTH*4, and adr[1:0]==0.
  - word index = (adr-BASE_ADDR)[log2(DEPTH)+1:2].
  - Out-of-range or misaligned accesses terminate with err.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On cyc&stb sampled high, latch adr, we, sel, dat_w and in_range.
  - Go to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), else RESP.
- WAIT:
  - Counter decrements each cycle; go to RESP when counter==0.
  - If cyc falls: abort to IDLE, no ack, no write.
- RESP:
  - Exactly one cycle of ack (in_range) or err (not in_range); ack and err are never high together.
  - Return to IDLE on the next edge unconditionally.
- Latency: ack/err is high in the cycle starting WAIT_STATES+1 edges after cyc&stb is first sampled. With WAIT_STATES=0, ack is registered on the next edge.
- Abort in RESP: if cyc is low in the RESP cycle, ack/err is still driven, but the write is suppressed.
- Write:
  - Committed at the RESP edge, only for bytes with sel[i]=1 and only when in_range.
  - sel==0 write: ack returned, memory unchanged.
- Read:
  - dat_r is loaded from RAM on entry to RESP and is valid while ack=1.
  - dat_r holds its last value otherwise.
  - On an err read, dat_r=32'h0.
  - sel is ignored for reads; the full word is returned.
- Back-to-back transfers:
  - stb still high in the IDLE cycle after RESP starts a new transaction.
  - The minimum transfer period is WAIT_STATES+2 cycles.
- Sampling: stb without cyc is ignored. Changes to adr/dat_w/we/sel after latching have no effect on the transfer in flight.
- Reset mid-transfer: the FSM goes to IDLE immediately, no ack/err is issued, and a pending write is dropped.

Decomposition:
- Package wb_target_mem_pkg:
  - state enum type (IDLE, WAIT, RESP).
  - WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4.
  - WAIT counter width constant (4).
- Sub-module wb_target_mem_ram:
  - single-port, synchronous-write, synchronous-read byte-enable RAM.
  - parameters DEPTH and data width 32; no reset on the storage array.
- wb_target_mem contains the decode, FSM, counter and output registers.

Test Plan:
- WAIT_STATES=0: write 32'hDEAD_BEEF to adr 0x10 with sel=4'hF, then read 0x10 -> ack 1 cycle after each strobe, dat_r=32'hDEAD_BEEF, err=0 throughout.
- Byte enables: write 32'h1122_3344 to 0x20 with sel=F, then write 32'hAABB_CCDD with sel=4'b0101, then read -> 32'h11BB_33DD.
- WAIT_STATES=3: read any address -> ack asserted exactly 4 edges after cyc&stb is first sampled, high for one cycle.
- Error cases: read 0x400 with DEPTH=256 -> err=1, ack=0, dat_r=0. Write to 0x12 (misaligned) -> err, and a subsequent read of 0x10 shows unchanged contents.
- Abort: WAIT_STATES=5, write to 0x30, drop cyc after 2 cycles -> no ack/err, and a later read of 0x30 returns the previous contents.
- Reset mid-transfer: assert reset during WAIT -> ack/err stay 0, FSM returns to IDLE. After reset, a read of a previously written word returns its retained value.

Source files
------------

// File: rtl/wb_target_mem_pkg.sv
// Shared types and widths for the Wishbone classic SRAM target.
package wb_target_mem_pkg;
    localparam int WB_ADR_W   = 32;
    localparam int WB_DAT_W   = 32;
    localparam int WB_SEL_W   = 4;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;
endpackage

// File: rtl/wb_target_mem_ram.sv
// Single-port byte-enable SRAM with a synchronous read register.
// Only the read register is reset; the storage array keeps its contents across reset.
module wb_target_mem_ram #(
    parameter int DEPTH = 256,
    parameter int DAT_W = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int BE_W = DAT_W / 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_en,
    input  logic             rd_clr,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [DAT_W-1:0] wdata,
    input  logic [BE_W-1:0]  be,
    output logic [DAT_W-1:0] rdata
);
    logic [DAT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || rd_clr) rdata <= '0;
        else if (rd_en)      rdata <= mem[addr];
    end
endmodule

// File: rtl/wb_target_mem.sv
// Wishbone B4 classic target: address decode, wait-state FSM and response
// generation in front of a byte-enable SRAM.
module wb_target_mem
    import wb_target_mem_pkg::*;
#(
    parameter int                    DEPTH       = 256,
    parameter int                    WAIT_STATES = 0,
    parameter logic [WB_ADR_W-1:0]   BASE_ADDR   = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WB_ADR_W-1:0] adr,
    input  logic [WB_DAT_W-1:0] dat_w,
    output logic [WB_DAT_W-1:0] dat_r,
    input  logic                stb,
    input  logic                cyc,
    input  logic                we,
    input  logic [WB_SEL_W-1:0] sel,
    output logic                ack,
    output logic                err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [WB_ADR_W:0] SPAN = (WB_ADR_W+1)'(DEPTH) * (WB_ADR_W+1)'(4);
    localparam bit HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
        HAS_WAIT ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    state_t                state, state_d;
    logic [WAIT_CNT_W-1:0] cnt, cnt_d;
    logic [AW-1:0]         idx_q;
    logic                  ok_q, we_q;
    logic [WB_SEL_W-1:0]   sel_q;
    logic [WB_DAT_W-1:0]   dat_q;

    // BASE_ADDR is aligned to the window size, so the word index is just adr bits.
    logic [WB_ADR_W-1:0] offset;
    logic                adr_ok;
    logic [AW-1:0]       adr_idx;
    assign offset  = adr - BASE_ADDR;
    assign adr_ok  = ({1'b0, offset} < SPAN) && (adr[1:0] == 2'b00);
    assign adr_idx = adr[AW+1:2];

    logic start, enter_resp;
    assign start = (state == IDLE) && cyc && stb;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: if (start) begin
                if (HAS_WAIT) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            WAIT: begin
                if (!cyc) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
            ok_q  <= 1'b0;
            we_q  <= 1'b0;
            sel_q <= '0;
            dat_q <= '0;
        end else if (start) begin
            idx_q <= adr_idx;
            ok_q  <= adr_ok;
            we_q  <= we;
            sel_q <= sel;
            dat_q <= dat_w;
        end
    end

    // With no wait states RESP is entered straight from IDLE, so use the live decode.
    logic          resp_ok, resp_we, rd_en, rd_clr, wr_en;
    logic [AW-1:0] ram_addr;
    assign resp_ok  = (state == IDLE) ? adr_ok : ok_q;
    assign resp_we  = (state == IDLE) ? we     : we_q;
    assign rd_en    = enter_resp &&  resp_ok && !resp_we;
    assign rd_clr   = enter_resp && !resp_ok && !resp_we;
    assign wr_en    = (state == RESP) && ok_q && we_q && cyc;
    assign ram_addr = (state == IDLE) ? adr_idx : idx_q;

    assign ack = (state == RESP) &&  ok_q;
    assign err = (state == RESP) && !ok_q;

    wb_target_mem_ram #(
        .DEPTH (DEPTH),
        .DAT_W (WB_DAT_W)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .rd_en  (rd_en),
        .rd_clr (rd_clr),
        .wr_en  (wr_en),
        .addr   (ram_addr),
        .wdata  (dat_q),
        .be     (sel_q),
        .rdata  (dat_r)
    );
endmodule

// File: tb/tb_wb_target_mem.sv
// Scoreboard bench: three targets with 0, 3 and 5 wait states on one clock/reset.
module tb_wb_target_mem;
    localparam int N = 3;
    localparam int WS_TAB [N] = '{0, 3, 5};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] adr [N];
    logic [31:0] dat_w [N];
    logic [31:0] dat_r [N];
    logic        stb [N];
    logic        cyc [N];
    logic        we [N];
    logic [3:0]  sel [N];
    logic        ack [N];
    logic        err [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : gen_dut
        wb_target_mem #(
            .DEPTH       (256),
            .WAIT_STATES (WS_TAB[g]),
            .BASE_ADDR   (32'h0000_0000)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .adr   (adr[g]),
            .dat_w (dat_w[g]),
            .dat_r (dat_r[g]),
            .stb   (stb[g]),
            .cyc   (cyc[g]),
            .we    (we[g]),
            .sel   (sel[g]),
            .ack   (ack[g]),
            .err   (err[g])
        );
    end

    typedef struct {
        int          inst;
        logic        is_ack;
        logic [31:0] data;
        logic        chk;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every ack/err cycle must match the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < N; g++) begin
            if (ack[g] === 1'b1 || err[g] === 1'b1) begin
                check($sformatf("ack_err_excl%0d", g), {31'b0, ack[g] & err[g]}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp inst%0d: got ack=%b err=%b expected none", g, ack[g], err[g]);
                end else begin
                    e = sb.pop_front();
                    check("resp_inst", 32'(g), 32'(e.inst));
                    check($sformatf("resp_ack%0d", g), {31'b0, ack[g]}, {31'b0, e.is_ack});
                    if (e.chk) check($sformatf("dat_r%0d", g), dat_r[g], e.data);
                end
            end
        end
    end

    // Full transfer; after the first edge the bus inputs are scrambled to show they were latched.
    task automatic xfer(input int g, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic exp_ack, input logic [31:0] exp_d,
                        input logic chk);
        int   lat;
        exp_t e;
        e = '{g, exp_ack, exp_d, chk};
        sb.push_back(e);
        @(negedge clk);
        adr[g] = a; dat_w[g] = d; we[g] = w; sel[g] = s; cyc[g] = 1'b1; stb[g] = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                adr[g] = ~a; dat_w[g] = ~d; sel[g] = ~s; we[g] = ~w;
            end
        end while (!(ack[g] | err[g]) && lat < 40);
        check($sformatf("latency%0d_%h", g, a), 32'(lat), 32'(WS_TAB[g] + 1));
        @(posedge clk); #1;
        cyc[g] = 1'b0; stb[g] = 1'b0; we[g] = 1'b0;
    endtask

    task automatic count_resp(input int g, input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (ack[g] !== 1'b0 || err[g] !== 1'b0) n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int g = 0; g < N; g++) begin
            adr[g] = '0; dat_w[g] = '0; stb[g] = 1'b0; cyc[g] = 1'b0; we[g] = 1'b0; sel[g] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) begin
            check($sformatf("rst_ack%0d", g), {31'b0, ack[g]}, 32'd0);
            check($sformatf("rst_err%0d", g), {31'b0, err[g]}, 32'd0);
            check($sformatf("rst_dat_r%0d", g), dat_r[g], 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // zero wait states: basic, byte enables, errors, sel==0, boundaries
        xfer(0, 1, 32'h10,  32'hDEAD_BEEF, 4'hF, 1, 32'h0, 0);
        xfer(0, 0, 32'h10,  32'h0,         4'hF, 1, 32'hDEAD_BEEF, 1);
        xfer(0, 1, 32'h20,  32'h1122_3344, 4'hF, 1, 32'h0, 0);
        xfer(0, 1, 32'h20,  32'hAABB_CCDD, 4'b0101, 1, 32'h0, 0);
        xfer(0, 0, 32'h20,  32'h0,         4'h0, 1, 32'h11BB_33DD, 1);
        xfer(0, 0, 32'h400, 32'h0,         4'hF, 0, 32'h0, 1);
        xfer(0, 1, 32'h12,  32'hFFFF_FFFF, 4'hF, 0, 32'h0, 0);
        xfer(0, 0, 32'h10,  32'h0,         4'hF, 1, 32'hDEAD_BEEF, 1);
        xfer(0, 1, 32'h10,  32'h0000_0000, 4'h0, 1, 32'h0, 0);
        xfer(0, 0, 32'h10,  32'h0,         4'hF, 1, 32'hDEAD_BEEF, 1);
        xfer(0, 1, 32'h3FC, 32'h5A5A_0FF0, 4'hF, 1, 32'h0, 0);
        xfer(0, 0, 32'h3FC, 32'h0,         4'hF, 1, 32'h5A5A_0FF0, 1);

        // strobe without cyc is ignored
        @(negedge clk);
        adr[0] = 32'h10; stb[0] = 1'b1; cyc[0] = 1'b0;
        count_resp(0, 4, n);
        check("stb_no_cyc", 32'(n), 32'd0);
        stb[0] = 1'b0;

        // three wait states
        xfer(1, 1, 32'h40,   32'h0BAD_F00D, 4'hF, 1, 32'h0, 0);
        xfer(1, 0, 32'h40,   32'h0,         4'hF, 1, 32'h0BAD_F00D, 1);
        xfer(1, 0, 32'h1000, 32'h0,         4'hF, 0, 32'h0, 1);
        xfer(1, 0, 32'h40,   32'h0,         4'hF, 1, 32'h0BAD_F00D, 1);

        // reset during WAIT drops the write and clears dat_r
        @(negedge clk);
        adr[1] = 32'h40; dat_w[1] = 32'h1234_5678; we[1] = 1'b1; sel[1] = 4'hF;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_dat_r", dat_r[1], 32'd0);
        @(negedge clk);
        reset = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        count_resp(1, 8, n);
        check("midrst_no_resp", 32'(n), 32'd0);
        xfer(1, 0, 32'h40, 32'h0, 4'hF, 1, 32'h0BAD_F00D, 1);

        // five wait states: abort by dropping cyc in WAIT
        xfer(2, 1, 32'h30, 32'hCAFE_0030, 4'hF, 1, 32'h0, 0);
        @(negedge clk);
        adr[2] = 32'h30; dat_w[2] = 32'h0000_DEAD; we[2] = 1'b1; sel[2] = 4'hF;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc[2] = 1'b0;
        count_resp(2, 10, n);
        check("abort_no_resp", 32'(n), 32'd0);
        stb[2] = 1'b0; we[2] = 1'b0;
        xfer(2, 0, 32'h30, 32'h0, 4'hF, 1, 32'hCAFE_0030, 1);

        repeat (5) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
